// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state type and frame length helper for piso_serializer
package serializer_pkg;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
  function automatic int frame_len(input int width);
`ifdef PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: frame bit counter with clear, increment and terminal-count flag
module piso_bit_counter #(
  parameter int CW   = 4,
  parameter int LAST = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign tc = cnt_q == CW'(LAST);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, one-bit-per-clock serial-out transmitter
// Define PARITY_EN to append an even-parity bit after the last data bit of each frame.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);
  localparam int FL = frame_len(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  ser_state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic shift, tc, accept, data_bit;
  assign shift      = state_q == SHIFT;
  assign ser_last   = shift && tc;
  assign load_ready = !shift || ser_last;
  assign accept     = load_valid && load_ready;
  assign ser_valid  = shift;
  assign busy       = shift;
  assign data_bit   = MSB_FIRST != 0 ? shreg_q[WIDTH-1] : shreg_q[0];
  always_comb begin
    state_d = accept ? SHIFT : ser_last ? IDLE : state_q;
    shreg_d = accept ? load_data : !shift ? shreg_q : MSB_FIRST != 0 ? shreg_q << 1 : shreg_q >> 1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end
`ifdef PARITY_EN
  logic par_q, par_d;
  always_comb par_d = accept ? ^load_data : par_q;
  always_ff @(posedge clk) par_q <= reset ? 1'b0 : par_d;
  // terminal count is the appended parity slot
  assign ser_out = shift && (tc ? par_q : data_bit);
`else
  assign ser_out = shift && data_bit;
`endif
  piso_bit_counter #(.CW(CW), .LAST(FL - 1)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (ser_last),
    .inc   (shift && !tc),
    .tc    (tc)
  );
endmodule
